// File: rtl/encoder_16_4_seq_if.sv
// Handshake bundle for the sequential 16-to-4 encoder (request side and index side).
// Latency: none, wires only.
// Backpressure: out_ready from the consumer stalls the index stream.
interface encoder_16_4_seq_if;
  logic        enable;
  logic        load;
  logic [15:0] req_in;
  logic        abort;
  logic        busy;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  binary_out;
  logic        done;
  logic [4:0]  count_out;

  // Requester/consumer side: drives requests and ready, observes the index stream.
  modport master (
    output enable, load, req_in, abort, out_ready,
    input  busy, out_valid, binary_out, done, count_out
  );

  // Encoder side.
  modport slave (
    input  enable, load, req_in, abort, out_ready,
    output busy, out_valid, binary_out, done, count_out
  );
endinterface

// File: rtl/encoder_16_4_seq.sv
// Sequential 16-to-4 encoder: emits the index of every set request bit, then pulses done with a count.
// Latency: first index valid 1 cycle after load; then one index per accepted handshake.
// Backpressure: out_ready=0 holds binary_out/out_valid stable; ENC_ROUND_ROBIN_EN selects rotating priority.
module encoder_16_4_seq (
  input logic               clk,
  input logic               reset_n,
  encoder_16_4_seq_if.slave bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EMIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]  state;
  logic [15:0] pending;
  logic [4:0]  emit_cnt;
  logic [3:0]  idx_q;
  logic        valid_q;
  logic        busy_q;
  logic        done_q;
  logic [4:0]  count_q;

  logic        handshake;
  logic [15:0] remaining;
  logic [3:0]  load_start;
  logic [3:0]  next_start;

  // First set bit of vec, scanning upward from start and wrapping 15->0.
  function automatic logic [3:0] pick(input logic [15:0] vec, input logic [3:0] start);
    logic [3:0] res;
    logic [3:0] pos;
    logic       found;
    res   = 4'd0;
    found = 1'b0;
    for (int k = 0; k < 16; k++) begin
      pos = start + 4'(k);
      if (!found && vec[pos]) begin
        res   = pos;
        found = 1'b1;
      end
    end
    return res;
  endfunction

`ifdef ENC_ROUND_ROBIN_EN
  logic [3:0] last_served;

  // Rotating priority: every scan begins just past the most recently accepted index.
  always_comb begin
    load_start = last_served + 4'd1;
    next_start = idx_q + 4'd1;
  end

  // Remember the last accepted index; survives abort and batch boundaries.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_served <= 4'd15;
    end else if (handshake && !bus.abort) begin
      last_served <= idx_q;
    end
  end
`else
  // Fixed priority: lowest set index always wins.
  always_comb begin
    load_start = 4'd0;
    next_start = 4'd0;
  end
`endif

  // Accepted transfer and the pending vector left once the current index is retired.
  always_comb begin
    handshake = (state == ST_EMIT) && valid_q && bus.out_ready;
    remaining = pending & ~(16'd1 << idx_q);
  end

  // Batch control: capture, emit one index per handshake, report completion or abort.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      pending  <= 16'd0;
      emit_cnt <= 5'd0;
      idx_q    <= 4'd0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      count_q  <= 5'd0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.load && bus.enable) begin
            emit_cnt <= 5'd0;
            busy_q   <= 1'b1;
            if (bus.req_in != 16'd0) begin
              pending <= bus.req_in;
              idx_q   <= pick(bus.req_in, load_start);
              valid_q <= 1'b1;
              state   <= ST_EMIT;
            end else begin
              // Empty batch completes straight away with a zero count.
              done_q  <= 1'b1;
              count_q <= 5'd0;
              state   <= ST_DONE;
            end
          end
        end
        ST_EMIT: begin
          if (bus.abort) begin
            // Abort wins over a simultaneous handshake; that index is not counted.
            pending <= 16'd0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            state   <= ST_IDLE;
          end else if (handshake) begin
            pending  <= remaining;
            emit_cnt <= emit_cnt + 5'd1;
            if (remaining != 16'd0) begin
              idx_q <= pick(remaining, next_start);
            end else begin
              valid_q <= 1'b0;
              done_q  <= 1'b1;
              count_q <= emit_cnt + 5'd1;
              state   <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end
        default: begin
          pending <= 16'd0;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.out_valid  = valid_q;
  assign bus.binary_out = idx_q;
  assign bus.done       = done_q;
  assign bus.count_out  = count_q;

endmodule

// File: tb/tb_encoder_16_4_seq.sv
// Bench for encoder_16_4_seq: directed scenarios plus random batches against an ordering model.
// Latency: checks first index one cycle after load and done one cycle after the last transfer.
// Backpressure: exercises held out_ready, random out_ready and abort.
module tb_encoder_16_4_seq;

  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  encoder_16_4_seq_if bus ();

  encoder_16_4_seq dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  int exp_q[$];
  int got_q[$];
  int model_last;
  int model_count;
  bit got_done;
  int got_count;

  // Expected emission order: set bits visited once around the ring starting after the last served index.
  function automatic void model_batch(input logic [15:0] v);
    int idx;
    exp_q = {};
    for (int k = 0; k < 16; k++) begin
`ifdef ENC_ROUND_ROBIN_EN
      idx = (model_last + 1 + k) % 16;
`else
      idx = k;
`endif
      if (v[idx]) exp_q.push_back(idx);
    end
  endfunction

  task automatic do_load(input logic [15:0] v, input logic en);
    bus.load   = 1'b1;
    bus.enable = en;
    bus.req_in = v;
    @(negedge clk);
    bus.load   = 1'b0;
    bus.enable = 1'b0;
    bus.req_in = 16'h0;
  endtask

  // Gather accepted indices until done (or give up); leaves the DUT idle at a falling edge.
  task automatic collect_batch(input bit rand_rdy);
    got_q = {};
    got_done = 1'b0;
    got_count = 0;
    for (int c = 0; c < 300 && !got_done; c++) begin
      if (bus.done === 1'b1) begin
        got_done  = 1'b1;
        got_count = int'(bus.count_out);
      end else begin
        bus.out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        if (bus.out_valid === 1'b1 && bus.out_ready) got_q.push_back(int'(bus.binary_out));
        @(negedge clk);
      end
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %0b want 0", bus.busy); end
    n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %0b want 0", bus.out_valid); end
    n_vec++; if (bus.binary_out !== 4'd0) begin n_err++; $display("FAIL reset_index got %0d want 0", bus.binary_out); end
    n_vec++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL reset_done got %0b want 0", bus.done); end
    n_vec++; if (bus.count_out !== 5'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", bus.count_out); end
    reset_n = 1'b1;
    model_last = 15;
    model_count = 0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    bus.out_ready = 1'b1;
    model_batch(16'h8421);
    do_load(16'h8421, 1'b1);
    n_vec++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL basic_latency valid got %0b want 1", bus.out_valid); end
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (bus.out_valid !== 1'b1 || int'(bus.binary_out) != exp_q[i]) begin
        n_err++; $display("FAIL basic_index[%0d] got v=%0b idx=%0d want v=1 idx=%0d", i, bus.out_valid, bus.binary_out, exp_q[i]);
      end
      @(negedge clk);
    end
    n_vec++; if (bus.done !== 1'b1) begin n_err++; $display("FAIL basic_done got %0b want 1", bus.done); end
    n_vec++; if (bus.count_out !== 5'd4) begin n_err++; $display("FAIL basic_count got %0d want 4", bus.count_out); end
    n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL basic_valid_off got %0b want 0", bus.out_valid); end
    @(negedge clk);
    n_vec++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin n_err++; $display("FAIL basic_idle got done=%0b busy=%0b want 0 0", bus.done, bus.busy); end
    model_last = exp_q[3];
    model_count = 4;
  endtask

  task automatic test_zero();
    do_load(16'h0000, 1'b1);
    n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL zero_valid got %0b want 0", bus.out_valid); end
    n_vec++; if (bus.done !== 1'b1) begin n_err++; $display("FAIL zero_done got %0b want 1", bus.done); end
    n_vec++; if (bus.count_out !== 5'd0) begin n_err++; $display("FAIL zero_count got %0d want 0", bus.count_out); end
    @(negedge clk);
    n_vec++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin n_err++; $display("FAIL zero_idle got busy=%0b done=%0b want 0 0", bus.busy, bus.done); end
    model_count = 0;
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    model_batch(16'h0006);
    do_load(16'h0006, 1'b1);
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (bus.out_valid !== 1'b1 || int'(bus.binary_out) != exp_q[0]) begin
        n_err++; $display("FAIL bp_hold[%0d] got v=%0b idx=%0d want v=1 idx=%0d", i, bus.out_valid, bus.binary_out, exp_q[0]);
      end
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      n_vec++;
      if (bus.out_valid !== 1'b1 || int'(bus.binary_out) != exp_q[i]) begin
        n_err++; $display("FAIL bp_index[%0d] got v=%0b idx=%0d want v=1 idx=%0d", i, bus.out_valid, bus.binary_out, exp_q[i]);
      end
      @(negedge clk);
    end
    n_vec++; if (bus.done !== 1'b1 || bus.count_out !== 5'd2) begin n_err++; $display("FAIL bp_done got done=%0b count=%0d want 1 2", bus.done, bus.count_out); end
    @(negedge clk);
    model_last = exp_q[1];
    model_count = 2;
  endtask

  task automatic test_abort();
    bus.out_ready = 1'b1;
    model_batch(16'hFFFF);
    do_load(16'hFFFF, 1'b1);
    repeat (3) @(negedge clk);
    n_vec++; if (int'(bus.binary_out) != exp_q[3]) begin n_err++; $display("FAIL abort_pre_index got %0d want %0d", bus.binary_out, exp_q[3]); end
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    n_vec++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin n_err++; $display("FAIL abort_idle got v=%0b busy=%0b want 0 0", bus.out_valid, bus.busy); end
    n_vec++; if (int'(bus.count_out) != model_count) begin n_err++; $display("FAIL abort_count got %0d want %0d", bus.count_out, model_count); end
    for (int i = 0; i < 3; i++) begin
      n_vec++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL abort_no_done[%0d] got %0b want 0", i, bus.done); end
      @(negedge clk);
    end
    model_last = exp_q[2];
  endtask

  task automatic test_enable_low();
    do_load(16'h00FF, 1'b0);
    n_vec++; if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin n_err++; $display("FAIL enable_low got busy=%0b v=%0b want 0 0", bus.busy, bus.out_valid); end
    @(negedge clk);
    n_vec++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin n_err++; $display("FAIL enable_low_late got busy=%0b done=%0b want 0 0", bus.busy, bus.done); end
  endtask

  task automatic test_load_busy();
    bus.out_ready = 1'b0;
    model_batch(16'h0003);
    do_load(16'h0003, 1'b1);
    do_load(16'hFFFF, 1'b1);
    collect_batch(1'b0);
    n_vec++; if (!got_done || got_q.size() != exp_q.size()) begin n_err++; $display("FAIL load_busy_len got done=%0b n=%0d want 1 %0d", got_done, got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_vec++; if (got_q[i] != exp_q[i]) begin n_err++; $display("FAIL load_busy_index[%0d] got %0d want %0d", i, got_q[i], exp_q[i]); end
    end
    n_vec++; if (got_count != 2) begin n_err++; $display("FAIL load_busy_count got %0d want 2", got_count); end
    if (exp_q.size() > 0) model_last = exp_q[exp_q.size()-1];
    model_count = 2;
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b1;
    do_load(16'h00F0, 1'b1);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    n_vec++; if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin n_err++; $display("FAIL async_reset got busy=%0b v=%0b want 0 0", bus.busy, bus.out_valid); end
    n_vec++; if (bus.binary_out !== 4'd0 || bus.done !== 1'b0 || bus.count_out !== 5'd0) begin
      n_err++; $display("FAIL async_reset_out got idx=%0d done=%0b count=%0d want 0 0 0", bus.binary_out, bus.done, bus.count_out);
    end
    @(negedge clk);
    reset_n = 1'b1;
    model_last = 15;
    model_count = 0;
    @(negedge clk);
    n_vec++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin n_err++; $display("FAIL async_reset_after got done=%0b busy=%0b want 0 0", bus.done, bus.busy); end
  endtask

  task automatic test_priority_order();
    int want0;
    int want1;
`ifdef ENC_ROUND_ROBIN_EN
    want0 = 6; want1 = 0;
`else
    want0 = 0; want1 = 6;
`endif
    bus.out_ready = 1'b1;
    do_load(16'h0020, 1'b1);
    collect_batch(1'b0);
    n_vec++; if (got_q.size() != 1 || got_q[0] != 5) begin n_err++; $display("FAIL prio_first got n=%0d want single index 5", got_q.size()); end
    do_load(16'h0041, 1'b1);
    collect_batch(1'b0);
    n_vec++;
    if (got_q.size() != 2) begin
      n_err++; $display("FAIL prio_second_len got %0d want 2", got_q.size());
    end else if (got_q[0] != want0 || got_q[1] != want1) begin
      n_err++; $display("FAIL prio_second got %0d,%0d want %0d,%0d", got_q[0], got_q[1], want0, want1);
    end
    model_last = want1;
    model_count = 2;
  endtask

  task automatic test_random();
    logic [15:0] v;
    for (int b = 0; b < 30; b++) begin
      v = 16'($urandom);
      if ($urandom_range(0, 2) == 0) v = v & 16'($urandom);
      if (b == 7) v = 16'hFFFF;
      model_batch(v);
      do_load(v, 1'b1);
      collect_batch(1'b1);
      n_vec++; if (!got_done) begin n_err++; $display("FAIL rand_timeout batch %0d vec %h", b, v); end
      n_vec++; if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL rand_len batch %0d vec %h got %0d want %0d", b, v, got_q.size(), exp_q.size()); end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
        n_vec++; if (got_q[i] != exp_q[i]) begin n_err++; $display("FAIL rand_index batch %0d pos %0d got %0d want %0d", b, i, got_q[i], exp_q[i]); end
      end
      n_vec++; if (got_count != exp_q.size()) begin n_err++; $display("FAIL rand_count batch %0d got %0d want %0d", b, got_count, exp_q.size()); end
      if (exp_q.size() > 0) model_last = exp_q[exp_q.size()-1];
      model_count = exp_q.size();
    end
  endtask

  initial begin
    bus.enable    = 1'b0;
    bus.load      = 1'b0;
    bus.req_in    = 16'h0;
    bus.abort     = 1'b0;
    bus.out_ready = 1'b0;
    reset_n       = 1'b0;
    model_last    = 15;
    model_count   = 0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_zero();
    test_backpressure();
    test_abort();
    test_enable_low();
    test_load_busy();
    test_reset_mid();
    test_priority_order();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout simulation did not finish, want completion");
    $fatal(1, "timeout");
  end

endmodule
